// File: rtl/led_pulse_pkg.sv
// Shared types and defaults for the LED pulse-train generator.
// Phase encoding is shared by the FSM and anything that wants to observe it.
package led_pulse_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ON   = 2'd2,
    OFF  = 2'd3
  } state_e;

endpackage

// File: rtl/led_phase_counter.sv
// Loadable down-counter shared by every phase of the pulse train.
// Holds at zero; the FSM reloads it whenever a phase ends.
module led_phase_counter
  import led_pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_pulse_gen.sv
// Timed LED pulse-train generator: wait, then N pulses of On/Off cycles.
// One phase counter is reloaded with (duration-1) at every phase change.
module led_pulse_gen
  import led_pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] TLEDNo,
  input  logic [CNT_W-1:0] TLEDOn,
  input  logic [CNT_W-1:0] TLEDOff,
  input  logic [CNT_W-1:0] TLEDWait,
  output logic             led,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  state_e           state;
  logic [CNT_W-1:0] lat_no;
  logic [CNT_W-1:0] lat_on;
  logic [CNT_W-1:0] lat_off;
  logic [CNT_W-1:0] pc_next;

  logic             ld;
  logic             en;
  logic [CNT_W-1:0] ld_val;
  logic             zero;

  // zero-length phases still last one cycle
  function automatic logic [CNT_W-1:0] m1(
    input logic [CNT_W-1:0] d
  );
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  assign pc_next = pulse_cnt + CNT_W'(1);

  always_comb begin
    ld     = 1'b0;
    en     = 1'b0;
    ld_val = '0;
    if (abort) begin
      ld = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ld     = 1'b1;
            ld_val = (TLEDWait != '0) ? m1(TLEDWait)
                                      : m1(TLEDOn);
          end
        end
        WAIT, OFF: begin
          if (zero) begin
            ld     = 1'b1;
            ld_val = m1(lat_on);
          end else begin
            en = 1'b1;
          end
        end
        ON: begin
          if (zero) begin
            ld     = 1'b1;
            ld_val = m1(lat_off);
          end else begin
            en = 1'b1;
          end
        end
      endcase
    end
  end

  led_phase_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ld),
    .en   (en),
    .value(ld_val),
    .zero (zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      lat_no    <= '0;
      lat_on    <= '0;
      lat_off   <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        led   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              lat_no    <= TLEDNo;
              lat_on    <= TLEDOn;
              lat_off   <= TLEDOff;
              pulse_cnt <= '0;
              if (TLEDNo == '0) begin
                done <= 1'b1;
              end else if (TLEDWait != '0) begin
                state <= WAIT;
                busy  <= 1'b1;
              end else begin
                state <= ON;
                busy  <= 1'b1;
                led   <= 1'b1;
              end
            end
          end
          WAIT, OFF: begin
            if (zero) begin
              state <= ON;
              led   <= 1'b1;
            end
          end
          ON: begin
            if (zero) begin
              led       <= 1'b0;
              pulse_cnt <= pc_next;
              if (pc_next == lat_no) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= OFF;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pulse_gen.sv
// Self-checking bench: per-cycle compare against a timeline model
// derived from start cycle and pulse arithmetic, plus literal pins.
module tb_led_pulse_gen;

  localparam int BIG = 1 << 30;

  typedef struct {
    int k;
    int n;
    int on;
    int off;
    int w;
    int ab;
    bit rst;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] TLEDNo = '0;
  logic [31:0] TLEDOn = '0;
  logic [31:0] TLEDOff = '0;
  logic [31:0] TLEDWait = '0;
  logic        led;
  logic        busy;
  logic        done;
  logic [31:0] pulse_cnt;

  int   cyc = 0;
  int   asserts = 0;
  int   fails = 0;
  rec_t q[$];
  int   rises[$];
  int   dones[$];
  bit   prev_led = 1'b0;

  led_pulse_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .TLEDNo   (TLEDNo),
    .TLEDOn   (TLEDOn),
    .TLEDOff  (TLEDOff),
    .TLEDWait (TLEDWait),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    asserts++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  function automatic int qget(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  // Expected outputs at cycle e from the latest train record.
  function automatic void model(input int e, output bit m_led,
                                output bit m_busy, output bit m_done,
                                output int m_pc);
    rec_t r;
    bit   found;
    int   base, p, ende, stop, t;
    m_led  = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_pc   = 0;
    found  = 1'b0;
    r      = '{0, 0, 1, 1, 0, BIG, 1'b1};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!found && q[i].k < e) begin
        r     = q[i];
        found = 1'b1;
      end
    end
    if (!found || r.rst) return;
    if (r.n == 0) begin
      m_done = (e == r.k + 1);
      return;
    end
    base   = r.k + 1 + r.w;
    p      = r.on + r.off;
    ende   = base + r.n * r.on + (r.n - 1) * r.off;
    stop   = (r.ab + 1 < ende) ? r.ab + 1 : ende;
    m_busy = (e < stop);
    m_led  = m_busy && e >= base && ((e - base) % p) < r.on;
    m_done = (e == ende) && (r.ab >= ende);
    t      = (e < r.ab) ? e : r.ab;
    if (t >= base + r.on) begin
      m_pc = (t - base - r.on) / p + 1;
      if (m_pc > r.n) m_pc = r.n;
    end
  endfunction

  always @(negedge clk) begin
    bit el, eb, ed;
    int ep;
    if (cyc >= 1) begin
      model(cyc, el, eb, ed, ep);
      chk("led", led, el);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("pulse_cnt", pulse_cnt, ep);
      if (led && !prev_led) rises.push_back(cyc);
      if (done) dones.push_back(cyc);
      prev_led = led;
    end
  end

  task automatic drive(input bit s, input bit a, input bit r);
    bit el, eb, ed;
    int ep;
    rec_t t;
    @(negedge clk);
    #1;
    start = s;
    abort = a;
    rst_n = r;
    if (!r) begin
      q.push_back('{cyc, 0, 1, 1, 0, BIG, 1'b1});
    end else begin
      model(cyc, el, eb, ed, ep);
      if (a && eb && q.size() > 0 && q[$].ab == BIG) begin
        t = q[$];
        t.ab = cyc;
        q[q.size()-1] = t;
      end else if (s && !a && !eb) begin
        t.k   = cyc;
        t.n   = int'(TLEDNo);
        t.on  = (TLEDOn == 0) ? 1 : int'(TLEDOn);
        t.off = (TLEDOff == 0) ? 1 : int'(TLEDOff);
        t.w   = int'(TLEDWait);
        t.ab  = BIG;
        t.rst = 1'b0;
        q.push_back(t);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic prog(input int n, input int on,
                      input int off, input int w);
    TLEDNo   = 32'(n);
    TLEDOn   = 32'(on);
    TLEDOff  = 32'(off);
    TLEDWait = 32'(w);
  endtask

  task automatic clr();
    rises.delete();
    dones.delete();
  endtask

  initial begin
    int k;
    q.push_back('{-1, 0, 1, 1, 0, BIG, 1'b1});
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    idle(2);
    chk("reset_led", led, 0);
    chk("reset_pc", pulse_cnt, 0);

    // basic train with ignored restart and mid-train write
    prog(3, 10, 100, 1);
    clr();
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(49);
    drive(1'b1, 1'b0, 1'b1);
    TLEDOn = 32'd5;
    idle(190);
    chk("s1_nrise", rises.size(), 3);
    chk("s1_rise0", qget(rises, 0), k + 2);
    chk("s1_rise1", qget(rises, 1), k + 112);
    chk("s1_rise2", qget(rises, 2), k + 222);
    chk("s1_done", qget(dones, 0), k + 232);
    chk("s1_pc", pulse_cnt, 3);

    // zero pulses
    prog(0, 10, 100, 1);
    clr();
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(5);
    chk("s2_done", qget(dones, 0), k + 1);
    chk("s2_nrise", rises.size(), 0);

    // zero durations
    prog(2, 0, 0, 0);
    clr();
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(8);
    chk("s3_rise0", qget(rises, 0), k + 1);
    chk("s3_rise1", qget(rises, 1), k + 3);
    chk("s3_done", qget(dones, 0), k + 4);

    // abort in second ON cycle of pulse 2
    prog(3, 10, 100, 1);
    clr();
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(112);
    drive(1'b0, 1'b1, 1'b1);
    idle(10);
    chk("s4_ndone", dones.size(), 0);
    chk("s4_pc", pulse_cnt, 1);
    chk("s4_busy", busy, 0);

    // abort with start in IDLE
    clr();
    drive(1'b1, 1'b1, 1'b1);
    idle(5);
    chk("s5_nrise", rises.size(), 0);
    chk("s5_ndone", dones.size(), 0);
    chk("s5_pc", pulse_cnt, 1);

    // restart in the done cycle
    prog(1, 3, 2, 2);
    clr();
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(5);
    drive(1'b1, 1'b0, 1'b1);
    idle(12);
    chk("s6_done0", qget(dones, 0), k + 6);
    chk("s6_rise1", qget(rises, 1), k + 9);
    chk("s6_done1", qget(dones, 1), k + 12);

    // reset during OFF, then a normal train
    prog(3, 10, 100, 1);
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(19);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("s7_led", led, 0);
    chk("s7_busy", busy, 0);
    chk("s7_pc", pulse_cnt, 0);
    prog(2, 2, 1, 0);
    clr();
    drive(1'b1, 1'b0, 1'b1);
    k = cyc;
    idle(10);
    chk("s7_done", qget(dones, 0), k + 6);
    chk("s7_pc2", pulse_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
